regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_if.sv | 54 +++++
 rtl/regfile_mp.sv | 142 ++++++++++++++
 tb/tb_regfile_mp.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_if
//  Brief    : Bus bundle for the two-write / two-read register file with
//             per-register pending (scoreboard) bits.
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   // Write port 0
   logic                  ctrl_writeEn0;
   logic [ADDR_WIDTH-1:0] ctrl_writeReg0;
   logic [DATA_WIDTH-1:0] data_writeReg0;
   // Write port 1 (wins over port 0 on an address collision)
   logic                  ctrl_writeEn1;
   logic [ADDR_WIDTH-1:0] ctrl_writeReg1;
   logic [DATA_WIDTH-1:0] data_writeReg1;
   // Read ports
   logic [ADDR_WIDTH-1:0] ctrl_readRegA;
   logic [ADDR_WIDTH-1:0] ctrl_readRegB;
   logic [DATA_WIDTH-1:0] data_readRegA;
   logic [DATA_WIDTH-1:0] data_readRegB;
   // Reservation / pending tracking
   logic                  ctrl_reserve;
   logic [ADDR_WIDTH-1:0] ctrl_reserveReg;
   logic                  busy_readRegA;
   logic                  busy_readRegB;
   logic [ADDR_WIDTH:0]   pending_count;

   // Requester side: issues writes, reads and reservations
   modport master (
      output ctrl_writeEn0, ctrl_writeReg0, data_writeReg0,
      output ctrl_writeEn1, ctrl_writeReg1, data_writeReg1,
      output ctrl_readRegA, ctrl_readRegB,
      output ctrl_reserve,  ctrl_reserveReg,
      input  data_readRegA, data_readRegB,
      input  busy_readRegA, busy_readRegB,
      input  pending_count
   );

   // Register file side
   modport slave (
      input  ctrl_writeEn0, ctrl_writeReg0, data_writeReg0,
      input  ctrl_writeEn1, ctrl_writeReg1, data_writeReg1,
      input  ctrl_readRegA, ctrl_readRegB,
      input  ctrl_reserve,  ctrl_reserveReg,
      output data_readRegA, data_readRegB,
      output busy_readRegA, busy_readRegB,
      output pending_count
   );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Brief    : Multi-ported register file, two write ports and two
//             combinational read ports, optional same-cycle forwarding,
//             optional hard-wired zero register and a per-register pending
//             bit with a registered population count.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  wire logic   clock,
   input  wire logic   ctrl_reset,   // asynchronous, active low
   regfile_mp_if.slave bus
);

   localparam int c_DEPTH = 2 ** ADDR_WIDTH;
   localparam int c_NRD   = 2;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
   logic [c_DEPTH-1:0]    r_pend;
   logic [ADDR_WIDTH:0]   r_count;

   // ------------------------------------------------------------------------
   // Per-register decode of this cycle's write / reserve requests
   // ------------------------------------------------------------------------
   logic [c_DEPTH-1:0]    w_wr_hit0;
   logic [c_DEPTH-1:0]    w_wr_hit1;
   logic [c_DEPTH-1:0]    w_rsv_hit;
   logic [c_DEPTH-1:0]    w_pend_next;
   logic [ADDR_WIDTH:0]   w_count_next;

   // Read port plumbing, indexed 0 = port A, 1 = port B
   logic [ADDR_WIDTH-1:0] w_raddr [c_NRD];
   logic [DATA_WIDTH-1:0] w_rdata [c_NRD];
   logic                  w_busy  [c_NRD];

   // Decode write and reserve targets; port 1 shadows port 0 on a collision,
   // and a hard-wired zero register never sees a write or reservation.
   always_comb begin
      w_wr_hit0 = '0;
      w_wr_hit1 = '0;
      w_rsv_hit = '0;
      for (int i = 0; i < c_DEPTH; i++) begin
         w_wr_hit1[i] = bus.ctrl_writeEn1 && (bus.ctrl_writeReg1 == ADDR_WIDTH'(i));
         w_wr_hit0[i] = bus.ctrl_writeEn0 && (bus.ctrl_writeReg0 == ADDR_WIDTH'(i))
                        && !w_wr_hit1[i];
         w_rsv_hit[i] = bus.ctrl_reserve && (bus.ctrl_reserveReg == ADDR_WIDTH'(i));
      end
      if (ZERO_REG != 0) begin
         w_wr_hit0[0] = 1'b0;
         w_wr_hit1[0] = 1'b0;
         w_rsv_hit[0] = 1'b0;
      end
   end

   // Next pending vector: a write clears its bit, a reservation sets it, and
   // the set is applied last so a same-cycle reserve+write leaves it pending.
   always_comb begin
      w_pend_next = (r_pend & ~(w_wr_hit0 | w_wr_hit1)) | w_rsv_hit;
   end

   // Population count of the next pending vector, registered alongside it so
   // the count and the bits always move on the same edge.
   always_comb begin
      w_count_next = '0;
      for (int i = 0; i < c_DEPTH; i++) begin
         w_count_next = w_count_next + {{ADDR_WIDTH{1'b0}}, w_pend_next[i]};
      end
   end

   // Register array update; reset clears every entry without waiting for a clock.
   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < c_DEPTH; i++) begin
            if (w_wr_hit1[i]) begin
               r_regs[i] <= bus.data_writeReg1;
            end else if (w_wr_hit0[i]) begin
               r_regs[i] <= bus.data_writeReg0;
            end
         end
      end
   end

   // Pending bits and their count; in-flight updates are dropped on reset.
   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         r_pend  <= '0;
         r_count <= '0;
      end else begin
         r_pend  <= w_pend_next;
         r_count <= w_count_next;
      end
   end

   // ------------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------------
   assign w_raddr[0] = bus.ctrl_readRegA;
   assign w_raddr[1] = bus.ctrl_readRegB;

   // Combinational read: stored value, optionally overridden by a matching
   // in-flight write (port 1 first). Busy is the registered bit only. The
   // forwarding path does not look at reset, so in-flight data still shows
   // while the array is held clear.
   always_comb begin
      for (int p = 0; p < c_NRD; p++) begin
         w_rdata[p] = r_regs[w_raddr[p]];
         w_busy[p]  = r_pend[w_raddr[p]];
         if (BYPASS != 0) begin
            if (bus.ctrl_writeEn1 && (bus.ctrl_writeReg1 == w_raddr[p])) begin
               w_rdata[p] = bus.data_writeReg1;
            end else if (bus.ctrl_writeEn0 && (bus.ctrl_writeReg0 == w_raddr[p])) begin
               w_rdata[p] = bus.data_writeReg0;
            end
         end
         if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
            w_rdata[p] = '0;
            w_busy[p]  = 1'b0;
         end
      end
   end

   assign bus.data_readRegA = w_rdata[0];
   assign bus.data_readRegB = w_rdata[1];
   assign bus.busy_readRegA = w_busy[0];
   assign bus.busy_readRegB = w_busy[1];
   assign bus.pending_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Brief    : Self-checking bench for regfile_mp. One instance forwards
//             same-cycle writes, a second identical-stimulus instance does
//             not. Expected values are queued as stimulus is applied and
//             compared on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

   localparam int K_RDA  = 0;  // forwarding DUT, data A
   localparam int K_RDB  = 1;  // forwarding DUT, data B
   localparam int K_BSA  = 2;  // forwarding DUT, busy A
   localparam int K_BSB  = 3;  // forwarding DUT, busy B
   localparam int K_CNT  = 4;  // forwarding DUT, pending count
   localparam int K_NRDA = 5;  // non-forwarding DUT, data A

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] exp;
   } sb_item_t;

   logic     clk   = 1'b0;
   logic     rst_n = 1'b0;
   sb_item_t sb [$];
   int       n_checks = 0;
   int       n_fails  = 0;

   regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();
   regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_n ();

   regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) u_dut_b (
      .clock      (clk),
      .ctrl_reset (rst_n),
      .bus        (bus_b)
   );

   regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(1)) u_dut_n (
      .clock      (clk),
      .ctrl_reset (rst_n),
      .bus        (bus_n)
   );

   // Both instances see identical stimulus
   assign bus_n.ctrl_writeEn0   = bus_b.ctrl_writeEn0;
   assign bus_n.ctrl_writeReg0  = bus_b.ctrl_writeReg0;
   assign bus_n.data_writeReg0  = bus_b.data_writeReg0;
   assign bus_n.ctrl_writeEn1   = bus_b.ctrl_writeEn1;
   assign bus_n.ctrl_writeReg1  = bus_b.ctrl_writeReg1;
   assign bus_n.data_writeReg1  = bus_b.data_writeReg1;
   assign bus_n.ctrl_readRegA   = bus_b.ctrl_readRegA;
   assign bus_n.ctrl_readRegB   = bus_b.ctrl_readRegB;
   assign bus_n.ctrl_reserve    = bus_b.ctrl_reserve;
   assign bus_n.ctrl_reserveReg = bus_b.ctrl_reserveReg;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         K_RDA:   return bus_b.data_readRegA;
         K_RDB:   return bus_b.data_readRegB;
         K_BSA:   return {31'b0, bus_b.busy_readRegA};
         K_BSB:   return {31'b0, bus_b.busy_readRegB};
         K_CNT:   return {26'b0, bus_b.pending_count};
         default: return bus_n.data_readRegA;
      endcase
   endfunction

   task automatic push(input string tag, input int kind, input logic [31:0] exp);
      sb_item_t it;
      it.tag  = tag;
      it.kind = kind;
      it.exp  = exp;
      sb.push_back(it);
   endtask

   task automatic idle();
      bus_b.ctrl_writeEn0   = 1'b0;
      bus_b.ctrl_writeReg0  = '0;
      bus_b.data_writeReg0  = '0;
      bus_b.ctrl_writeEn1   = 1'b0;
      bus_b.ctrl_writeReg1  = '0;
      bus_b.data_writeReg1  = '0;
      bus_b.ctrl_readRegA   = '0;
      bus_b.ctrl_readRegB   = '0;
      bus_b.ctrl_reserve    = 1'b0;
      bus_b.ctrl_reserveReg = '0;
   endtask

   task automatic wr0(input int a, input logic [31:0] d);
      bus_b.ctrl_writeEn0  = 1'b1;
      bus_b.ctrl_writeReg0 = 5'(a);
      bus_b.data_writeReg0 = d;
   endtask

   task automatic wr1(input int a, input logic [31:0] d);
      bus_b.ctrl_writeEn1  = 1'b1;
      bus_b.ctrl_writeReg1 = 5'(a);
      bus_b.data_writeReg1 = d;
   endtask

   task automatic rsv(input int a);
      bus_b.ctrl_reserve    = 1'b1;
      bus_b.ctrl_reserveReg = 5'(a);
   endtask

   // Compare everything queued against the outputs at the falling edge, then
   // let the rising edge commit the driven inputs.
   task automatic step();
      sb_item_t it;
      @(negedge clk);
      while (sb.size() > 0) begin
         it = sb.pop_front();
         chk(it.tag, observe(it.kind), it.exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      bus_b.ctrl_readRegA = 5'd5;
      bus_b.ctrl_readRegB = 5'd6;
      push("rst_cnt", K_CNT, 32'd0);
      push("rst_rdA", K_RDA, 32'd0);
      push("rst_bsB", K_BSB, 32'd0);
      step();
      rst_n = 1'b1;

      // Fill every register through port 0
      for (int a = 0; a < 32; a++) begin
         idle();
         wr0(a, 32'h0000DEAD);
         step();
      end
      for (int a = 0; a < 32; a++) begin
         idle();
         bus_b.ctrl_readRegA = 5'(a);
         bus_b.ctrl_readRegB = 5'(31 - a);
         push($sformatf("fillA%0d", a), K_RDA, (a == 0) ? 32'd0 : 32'h0000DEAD);
         push($sformatf("fillB%0d", 31 - a), K_RDB, (a == 31) ? 32'd0 : 32'h0000DEAD);
         step();
      end

      // Write collision: port 1 wins
      idle();
      wr0(5, 32'h11111111);
      wr1(5, 32'h22222222);
      step();
      idle();
      bus_b.ctrl_readRegA = 5'd5;
      push("coll_r5", K_RDA, 32'h22222222);
      step();

      // Forwarding versus stored value
      idle();
      wr0(7, 32'hCAFEF00D);
      bus_b.ctrl_readRegA = 5'd7;
      push("byp_r7", K_RDA, 32'hCAFEF00D);
      push("nobyp_r7", K_NRDA, 32'h0000DEAD);
      step();
      idle();
      bus_b.ctrl_readRegA = 5'd7;
      push("byp_r7_next", K_RDA, 32'hCAFEF00D);
      push("nobyp_r7_next", K_NRDA, 32'hCAFEF00D);
      step();

      // Double-match forwarding: port 1 priority
      idle();
      wr0(8, 32'h00000001);
      wr1(8, 32'h00000002);
      bus_b.ctrl_readRegA = 5'd8;
      bus_b.ctrl_readRegB = 5'd8;
      push("byp2_rB", K_RDB, 32'h00000002);
      push("nobyp2_rA", K_NRDA, 32'h0000DEAD);
      step();

      // Zero register never forwards
      idle();
      wr1(0, 32'hFFFFFFFF);
      bus_b.ctrl_readRegA = 5'd0;
      push("zero_byp", K_RDA, 32'd0);
      step();

      // Reservations
      idle();
      rsv(3);
      bus_b.ctrl_readRegA = 5'd3;
      push("rsv3_cnt_pre", K_CNT, 32'd0);
      push("rsv3_busy_pre", K_BSA, 32'd0);
      step();
      idle();
      rsv(4);
      push("rsv4_cnt", K_CNT, 32'd1);
      step();
      idle();
      rsv(4);
      push("rsv4b_cnt", K_CNT, 32'd2);
      step();
      idle();
      bus_b.ctrl_readRegA = 5'd4;
      push("rsv_cnt2", K_CNT, 32'd2);
      push("rsv_busy4", K_BSA, 32'd1);
      step();
      idle();
      wr0(4, 32'h00000044);
      bus_b.ctrl_readRegA = 5'd4;
      push("wr4_busy_same", K_BSA, 32'd1);
      step();
      idle();
      rsv(3);
      wr0(3, 32'h00000033);
      bus_b.ctrl_readRegA = 5'd4;
      bus_b.ctrl_readRegB = 5'd3;
      push("wr4_cnt", K_CNT, 32'd1);
      push("wr4_busy", K_BSA, 32'd0);
      push("rw3_busy_pre", K_BSB, 32'd1);
      step();
      idle();
      bus_b.ctrl_readRegA = 5'd3;
      push("rw3_busy", K_BSA, 32'd1);
      push("rw3_data", K_RDA, 32'h00000033);
      push("rw3_cnt", K_CNT, 32'd1);
      step();
      idle();
      rsv(0);
      step();
      idle();
      bus_b.ctrl_readRegA = 5'd0;
      push("rsv0_cnt", K_CNT, 32'd1);
      push("rsv0_busy", K_BSA, 32'd0);
      step();

      // Asynchronous reset in the middle of a cycle with updates in flight
      idle();
      rsv(9);
      wr0(10, 32'hA5A5A5A5);
      bus_b.ctrl_readRegA = 5'd3;
      bus_b.ctrl_readRegB = 5'd10;
      #2;
      rst_n = 1'b0;
      push("arst_cnt", K_CNT, 32'd0);
      push("arst_busy3", K_BSA, 32'd0);
      push("arst_data3", K_RDA, 32'd0);
      push("arst_fwd10", K_RDB, 32'hA5A5A5A5);
      step();
      idle();
      rst_n = 1'b1;
      bus_b.ctrl_readRegA = 5'd10;
      bus_b.ctrl_readRegB = 5'd9;
      push("post_r10", K_RDA, 32'd0);
      push("post_busy9", K_BSB, 32'd0);
      push("post_cnt", K_CNT, 32'd0);
      step();
      idle();
      wr0(10, 32'h00000001);
      step();
      idle();
      bus_b.ctrl_readRegA = 5'd10;
      push("post_wr10", K_RDA, 32'h00000001);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
